maze_run_seq: RTL

MAZE_RUN_SEQ -- requirements
Module: maze_run_seq

---
 rtl/maze_pkg.sv | 28 ++
 rtl/maze_step_calc.sv | 39 +++
 rtl/maze_run_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze run sequencer: direction encodings,
// grid bounds, completion status codes and sequencer states.
package maze_pkg;

    localparam int          GRID_SIZE = 10;
    localparam logic [3:0]  GRID_MAX  = 4'(GRID_SIZE - 1);

    localparam logic [3:0]  DIR_UP    = 4'b0001;
    localparam logic [3:0]  DIR_DOWN  = 4'b0010;
    localparam logic [3:0]  DIR_LEFT  = 4'b0100;
    localparam logic [3:0]  DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_NO_PATH  = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_BAD_PATH = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_PLAY,
        S_FIN
    } state_t;

endpackage

// File: rtl/maze_step_calc.sv
// Combinational next-position and legality check for a single move on the grid.
module maze_step_calc
    import maze_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic [3:0] dir,
    output logic [3:0] next_row,
    output logic [3:0] next_col,
    output logic       legal
);

    always_comb begin
        next_row = row;
        next_col = col;
        legal    = 1'b0;
        // Anything other than one of the four one-hot codes is illegal.
        case (dir)
            DIR_UP: begin
                legal    = (row != 4'd0);
                next_row = row - 4'd1;
            end
            DIR_DOWN: begin
                legal    = (row < GRID_MAX);
                next_row = row + 4'd1;
            end
            DIR_LEFT: begin
                legal    = (col != 4'd0);
                next_col = col - 4'd1;
            end
            DIR_RIGHT: begin
                legal    = (col < GRID_MAX);
                next_col = col + 4'd1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/maze_run_seq.sv
// Sequencer that launches a path-finding engine, waits for its verdict, then
// replays the found path one handshaked move at a time.
module maze_run_seq
    import maze_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 600000,
    parameter int START_ROW      = 9,
    parameter int START_COL      = 0,
    parameter int GOAL_ROW       = 0,
    parameter int GOAL_COL       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       busy,
    output logic       eng_start,
    input  logic       eng_path_ready,
    input  logic       eng_no_path,
    input  logic [6:0] eng_path_length,
    output logic [6:0] path_idx,
    input  logic [3:0] path_dir,
    output logic       move_valid,
    output logic [3:0] move_dir,
    input  logic       move_ready,
    output logic [3:0] pos_row,
    output logic [3:0] pos_col,
    output logic       done,
    output logic [1:0] status
);

    localparam int         CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] S_ROW  = 4'(START_ROW);
    localparam logic [3:0] S_COL  = 4'(START_COL);
    localparam logic [3:0] G_ROW  = 4'(GOAL_ROW);
    localparam logic [3:0] G_COL  = 4'(GOAL_COL);

    state_t        state, state_nxt;
    status_t       status_q, status_nxt;
    logic [3:0]    row_nxt, col_nxt;
    logic [6:0]    idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    step_row, step_col;
    logic          step_legal;

    maze_step_calc u_step (
        .row      (pos_row),
        .col      (pos_col),
        .dir      (path_dir),
        .next_row (step_row),
        .next_col (step_col),
        .legal    (step_legal)
    );

    assign busy      = (state != S_IDLE);
    assign eng_start = (state == S_LAUNCH);
    assign done      = (state == S_FIN);
    assign move_dir  = path_dir;
    assign status    = status_q;

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        row_nxt    = pos_row;
        col_nxt    = pos_col;
        idx_nxt    = path_idx;
        cnt_nxt    = cnt;
        move_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // Run context is cleared on acceptance so LAUNCH already shows it.
                if (req) begin
                    state_nxt  = S_LAUNCH;
                    status_nxt = ST_OK;
                    row_nxt    = S_ROW;
                    col_nxt    = S_COL;
                    idx_nxt    = '0;
                    cnt_nxt    = '0;
                end
            end
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt != CNT_LAST) cnt_nxt = cnt + 1'b1;
                if (eng_no_path) begin
                    state_nxt  = S_FIN;
                    status_nxt = ST_NO_PATH;
                end else if (eng_path_ready) begin
                    state_nxt = S_PLAY;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = S_FIN;
                    status_nxt = ST_TIMEOUT;
                end
            end
            S_PLAY: begin
                if (path_idx == eng_path_length) begin
                    state_nxt  = S_FIN;
                    status_nxt = (pos_row == G_ROW && pos_col == G_COL) ? ST_OK : ST_BAD_PATH;
                end else if (!step_legal) begin
                    state_nxt  = S_FIN;
                    status_nxt = ST_BAD_PATH;
                end else begin
                    move_valid = 1'b1;
                    if (move_ready) begin
                        row_nxt = step_row;
                        col_nxt = step_col;
                        idx_nxt = path_idx + 7'd1;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
            pos_row  <= S_ROW;
            pos_col  <= S_COL;
            path_idx <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
            pos_row  <= row_nxt;
            pos_col  <= col_nxt;
            path_idx <= idx_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule
